// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the redirect-cycle fetch (delay slot) instead of squashing it.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_off_ext,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [15:0] if_id_imm16
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned JIDX_W = 26;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          if_id_q, if_id_d;

  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   br_target;
  logic [XLEN-1:0]   j_target;
  logic [JIDX_W-1:0] j_index;
  logic              redirect;
  logic              squash;

  // Target arithmetic is relative to the PC+4 of the branch/jump sitting in ID.
  always_comb begin
    j_index   = jump_index;
    pc_plus4  = pc_q + XLEN'(4);
    br_target = if_id_q.pc4 + (branch_off_ext << 2);
    j_target  = {if_id_q.pc4[XLEN-1:XLEN-4], j_index, 2'b00};
    redirect  = jump | branch_taken;
`ifdef BRANCH_DELAY_SLOT_EN
    squash    = flush;
`else
    squash    = flush | redirect;
`endif
  end

  // Next-state: stall freezes everything; otherwise jump > branch > sequential.
  always_comb begin
    pc_d    = pc_q;
    if_id_d = if_id_q;
    if (!stall) begin
      if (jump) begin
        pc_d = j_target;
      end else if (branch_taken) begin
        pc_d = br_target;
      end else begin
        pc_d = pc_plus4;
      end

      if (squash) begin
        if_id_d.instr = NOP_INSTR;
        if_id_d.valid = 1'b0;
      end else begin
        if_id_d.instr = imem_data;
        if_id_d.valid = 1'b1;
      end
      if_id_d.pc4 = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      if_id_q.instr <= NOP_INSTR;
      if_id_q.pc4   <= '0;
      if_id_q.valid <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_valid = if_id_q.valid;
  assign if_id_imm16 = if_id_q.instr[IMM_W-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table with a scoreboard queue plus reset sequences.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DSLOT = 1'b1;
`else
  localparam bit DSLOT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_off_ext;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [15:0] if_id_imm16;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_off_ext(branch_off_ext),
    .jump(jump), .jump_index(jump_index),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .if_id_imm16(if_id_imm16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st, fl, br, jp;
    logic [31:0] boff;
    logic [25:0] jidx;
    logic [31:0] imem;
    logic [31:0] e_pc, e_instr, e_pc4;
    logic        e_valid;
  } vec_t;

  typedef struct {
    logic [31:0] pc, instr, pc4;
    logic        valid;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic st, fl, br, jp, input logic [31:0] boff,
                              input logic [25:0] jidx, input logic [31:0] imem,
                              input logic [31:0] e_pc, e_instr, e_pc4, input logic e_valid);
    vec_t v;
    v.st = st; v.fl = fl; v.br = br; v.jp = jp;
    v.boff = boff; v.jidx = jidx; v.imem = imem;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
    return v;
  endfunction

  // Expected IF/ID word after a redirect: kept in delay-slot build, NOP otherwise.
  function automatic logic [31:0] sq_instr(input logic [31:0] fetched);
    return DSLOT ? fetched : NOP;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_off_ext = '0; jump_index = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //            st fl br jp boff           jidx           imem           pc             instr                      pc4            valid
    vt.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,         32'h2008_0005, 32'h0000_0004, 32'h2008_0005,             32'h0000_0004, 1'b1));
    vt.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,         32'h1111_0001, 32'h0000_0008, 32'h1111_0001,             32'h0000_0008, 1'b1));
    vt.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,         32'h2222_0002, 32'h0000_000C, 32'h2222_0002,             32'h0000_000C, 1'b1));
    vt.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,         32'h3333_0003, 32'h0000_0010, 32'h3333_0003,             32'h0000_0010, 1'b1));
    vt.push_back(mk(0, 0, 1, 0, 32'hFFFF_FFFC, 26'h0,         32'h4444_0004, 32'h0000_0000, sq_instr(32'h4444_0004),   32'h0000_0014, DSLOT));
    vt.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,         32'h5555_0005, 32'h0000_0004, 32'h5555_0005,             32'h0000_0004, 1'b1));
    vt.push_back(mk(0, 0, 1, 0, 32'h1000_0000, 26'h0,         32'h6666_0006, 32'h4000_0004, sq_instr(32'h6666_0006),   32'h0000_0008, DSLOT));
    vt.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,         32'h7777_0007, 32'h4000_0008, 32'h7777_0007,             32'h4000_0008, 1'b1));
    vt.push_back(mk(0, 0, 1, 1, 32'h0000_0004, 26'h000_0040,  32'h8888_0008, 32'h4000_0100, sq_instr(32'h8888_0008),   32'h4000_000C, DSLOT));
    vt.push_back(mk(0, 1, 0, 0, 32'h0,         26'h0,         32'h9999_0009, 32'h4000_0104, NOP,                       32'h4000_0104, 1'b0));
    vt.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,         32'hAAAA_000A, 32'h4000_0108, 32'hAAAA_000A,             32'h4000_0108, 1'b1));
    vt.push_back(mk(1, 1, 1, 0, 32'h0000_0010, 26'h0,         32'hBBBB_000B, 32'h4000_0108, 32'hAAAA_000A,             32'h4000_0108, 1'b1));
    vt.push_back(mk(1, 0, 1, 1, 32'h0000_0010, 26'h3FF_FFFF,  32'hBBBB_000B, 32'h4000_0108, 32'hAAAA_000A,             32'h4000_0108, 1'b1));
    vt.push_back(mk(1, 0, 1, 0, 32'h0000_0010, 26'h0,         32'hBBBB_000B, 32'h4000_0108, 32'hAAAA_000A,             32'h4000_0108, 1'b1));
    vt.push_back(mk(0, 0, 1, 0, 32'h0000_0010, 26'h0,         32'hBBBB_000B, 32'h4000_0148, sq_instr(32'hBBBB_000B),   32'h4000_010C, DSLOT));
    vt.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,         32'hCCCC_000C, 32'h4000_014C, 32'hCCCC_000C,             32'h4000_014C, 1'b1));
    vt.push_back(mk(0, 0, 1, 0, 32'h2FFF_FFAC, 26'h0,         32'hDDDD_000D, 32'hFFFF_FFFC, sq_instr(32'hDDDD_000D),   32'h4000_0150, DSLOT));
    vt.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,         32'hEEEE_000E, 32'h0000_0000, 32'hEEEE_000E,             32'h0000_0000, 1'b1));
    vt.push_back(mk(0, 0, 0, 1, 32'h0,         26'h3FF_FFFF,  32'hF0F0_8001, 32'h0FFF_FFFC, sq_instr(32'hF0F0_8001),   32'h0000_0004, DSLOT));
    vt.push_back(mk(0, 1, 1, 0, 32'h0000_0001, 26'h0,         32'h1234_5678, 32'h0000_0008, NOP,                       32'h1000_0000, 1'b0));
    vt.push_back(mk(0, 0, 0, 0, 32'h0,         26'h0,         32'hABCD_0123, 32'h0000_000C, 32'hABCD_0123,             32'h0000_000C, 1'b1));

    // Power-on reset held across two edges.
    rst_n = 1'b0;
    drive_idle();
    imem_data = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pc",    pc,          32'h0);
    check("reset_instr", if_id_instr, NOP);
    check("reset_pc4",   if_id_pc4,   32'h0);
    check("reset_valid", 32'(if_id_valid), 32'h0);

    rst_n = 1'b1;
    foreach (vt[i]) begin
      exp_t e;
      stall = vt[i].st; flush = vt[i].fl; branch_taken = vt[i].br; jump = vt[i].jp;
      branch_off_ext = vt[i].boff; jump_index = vt[i].jidx; imem_data = vt[i].imem;
      e.pc = vt[i].e_pc; e.instr = vt[i].e_instr; e.pc4 = vt[i].e_pc4; e.valid = vt[i].e_valid;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL scoreboard_empty: vector %0d had no expected entry", i);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check($sformatf("v%0d_pc", i),    pc,          x.pc);
        check($sformatf("v%0d_imem", i),  imem_addr,   x.pc);
        check($sformatf("v%0d_instr", i), if_id_instr, x.instr);
        check($sformatf("v%0d_pc4", i),   if_id_pc4,   x.pc4);
        check($sformatf("v%0d_valid", i), 32'(if_id_valid), 32'(x.valid));
        check($sformatf("v%0d_imm16", i), 32'(if_id_imm16), 32'(x.instr[15:0]));
      end
      @(negedge clk);
    end

    // Mid-cycle asynchronous reset clears state before any edge.
    drive_idle();
    imem_data = 32'h0BAD_F00D;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pc",    pc,          32'h0);
    check("midrst_addr",  imem_addr,   32'h0);
    check("midrst_instr", if_id_instr, NOP);
    check("midrst_pc4",   if_id_pc4,   32'h0);
    check("midrst_valid", 32'(if_id_valid), 32'h0);

    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("release_pc", pc, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("release_pc_%0d", k), pc, 32'(4 * k));
      check($sformatf("release_pc4_%0d", k), if_id_pc4, 32'(4 * k));
      check($sformatf("release_valid_%0d", k), 32'(if_id_valid), 32'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
